hazard_tracker: RTL
===================

Name: hazard_tracker

Overview:
- Parametrised hazard and forwarding controller for the pipelined datapath, generalising its fixed 5-stage, hazard-free flow to a configurable number of post-decode stages.
- Tracks destination registers of in-flight instructions in an internal shift pipeline.
- Produces, in the same cycle as decode, a decode stall, per-operand forwarding selects and a stall counter.
- Sits beside the decode stage; its selects drive the operand muxes in front of the ALU and the branch comparator.

Parameters:
- REG_AW, 5, register address width.
- DEPTH, 3, number of tracked stages after decode (index 0 = execute, DEPTH-1 = writeback).
- LOAD_LAT, 2, stage index whose output first carries load data; a load in stage k < LOAD_LAT cannot be forwarded.
- SEL_W, $clog2(DEPTH+1), forwarding select width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- hold  in  1  global freeze (memory wait); all state holds.
- issue_valid  in  1  decode holds a real instruction.
- rs_d  in  REG_AW  source A address in decode.
- rt_d  in  REG_AW  source B address in decode.
- use_rs  in  1  instruction reads rs.
- use_rt  in  1  instruction reads rt.
- is_branch_d  in  1  decode-stage branch; operands needed in decode.
- dest_d  in  REG_AW  destination address (post RegDst mux).
- we_d  in  1  instruction writes the register file.
- load_d  in  1  instruction is a load.
- flush_e  in  1  kill the instruction entering execute.
- stall_d  out  1  freeze fetch/decode, inject bubble.
- fwd_a  out  SEL_W  0 = register file, k+1 = result of stage k.
- fwd_b  out  SEL_W  same for rt.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State: DEPTH entries {valid, dest, we, load}.
- Reset (reset low, async): all entries invalid and stall_cnt = 0. With no valid entries, stall_d = 0 and fwd_a = fwd_b = 0.
- Match for a source s at stage k: entry valid, we = 1, dest = s, s != 0, and the use_* bit is set. Register 0 never matches.
- Youngest match wins: the lowest k takes priority.
- fwd_x = k+1 for the youngest match, else 0. Combinational from state and decode inputs (zero latency).
- Load-use stall: the youngest match is a load with k < LOAD_LAT.
- Branch stall (is_branch_d = 1): any youngest match at k = 0, or a load match with k < LOAD_LAT+1.
- stall_d = issue_valid AND (load-use stall OR branch stall), for either operand. While stall_d = 1, fwd outputs are don't-care.
- Clock edge, hold = 0:
  - entry[k+1] <= entry[k] for k = 0..DEPTH-2; entry DEPTH-1 retires.
  - entry[0] <= bubble if stall_d, flush_e or !issue_valid; else {1, dest_d, we_d, load_d}.
- Clock edge, hold = 1: all entries and stall_cnt unchanged; hold has priority over stall and flush.
- stall_d and flush_e together insert exactly one bubble.
- stall_cnt increments on each non-hold edge with stall_d = 1, and saturates at all-ones.
- Reset mid-stall: entries clear immediately and stall_d drops the same cycle.
- DEPTH = 1 is legal: only execute is tracked and LOAD_LAT is clamped to 1.

Decomposition:
- Shared package holds:
  - the entry struct typedef {valid, dest, we, load};
  - the FWD_RF = 0 constant;
  - a function computing SEL_W.
- Natural sub-module: hazard_match, a combinational per-operand priority search returning {hit, k, is_load}, instantiated twice (rs, rt).
- Shift pipeline, stall logic and counter stay in hazard_tracker.

Test Plan:
- Reset, then issue add r3 (dest 3, we) followed by a dependent sub reading rs = 3 next cycle -> fwd_a = 1, stall_d = 0. One cycle later, an independent reader of r3 gets fwd_a = 2; two cycles later, fwd_a = 3.
- lw r5 then an immediate reader of rt = 5 (LOAD_LAT = 2) -> stall_d = 1 for 2 cycles; fwd_b = 3 on release; stall_cnt = 2.
- Writes to r0 (dest 0, we) then a reader of rs = 0 -> fwd_a = 0, stall_d = 0.
- add r4 at k = 0 and lw r4 at k = 2, reader of rs = 4 -> youngest wins: fwd_a = 1, no stall.
- beq reading r6 right after add r6 -> stall_d = 1 for one cycle, then fwd_a = 2.
- Load-use stall with hold = 1 for 3 cycles -> entries frozen, stall_d stays 1, stall_cnt unchanged.
- Assert reset low mid-stall -> stall_d = 0 immediately, stall_cnt = 0.
- flush_e with stall_d -> one bubble only; later readers see no match.

Source files
------------

// File: rtl/hazard_tracker_pkg.sv
// Shared types and helpers for the hazard/forwarding controller.
//   entry_t    : one tracked pipeline slot {valid, dest, we, load}
//   FWD_RF     : forwarding select value meaning "take the register file"
//   sel_width  : width of a select able to encode 0..DEPTH
package hazard_tracker_pkg;

  // Destination field is sized for the widest supported register address;
  // narrower addresses are zero-extended on entry and on compare.
  localparam int unsigned MAX_REG_AW = 8;

  localparam int unsigned FWD_RF = 0;

  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] dest;
    logic                  we;
    logic                  load;
  } entry_t;

  function automatic int unsigned sel_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand priority search over the tracked stages.
//   entries_i : tracked stages, index 0 = execute (youngest)
//   src_i     : source register address read in decode
//   use_i     : decode instruction actually reads src_i
//   hit_o     : some stage will write src_i
//   k_o       : index of the youngest writing stage
//   is_load_o : that youngest writer is a load
module hazard_match
  import hazard_tracker_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned SEL_W  = sel_width(DEPTH)
) (
  input  entry_t            entries_i [DEPTH],
  input  logic [REG_AW-1:0] src_i,
  input  logic              use_i,
  output logic              hit_o,
  output logic [SEL_W-1:0]  k_o,
  output logic              is_load_o
);

  // Scan oldest to youngest so the lowest matching index overwrites the rest.
  always_comb begin
    hit_o     = 1'b0;
    k_o       = '0;
    is_load_o = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (use_i && (src_i != '0) && entries_i[i].valid && entries_i[i].we &&
          (entries_i[i].dest == MAX_REG_AW'(src_i))) begin
        hit_o     = 1'b1;
        k_o       = SEL_W'(i);
        is_load_o = entries_i[i].load;
      end
    end
  end

endmodule

// File: rtl/hazard_tracker.sv
// Hazard and forwarding controller sitting beside decode.
//   clk, reset            : clock, async active-low reset
//   hold                  : global freeze, all state holds
//   issue_valid           : decode holds a real instruction
//   rs_d/rt_d, use_rs/rt  : decode source operands and their read enables
//   is_branch_d           : operands are consumed in decode by the comparator
//   dest_d, we_d, load_d  : decode instruction's writeback attributes
//   flush_e               : kill the instruction entering execute
//   stall_d               : freeze fetch/decode and inject a bubble
//   fwd_a/fwd_b           : 0 = register file, k+1 = result of stage k
//   stall_cnt             : saturating count of stall cycles
module hazard_tracker
  import hazard_tracker_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned SEL_W    = sel_width(DEPTH),
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic              is_branch_d,
  input  logic [REG_AW-1:0] dest_d,
  input  logic              we_d,
  input  logic              load_d,
  input  logic              flush_e,
  output logic              stall_d,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  // With only execute tracked, load data can first be taken after execute.
  localparam int unsigned LD_LAT = (DEPTH == 1) ? 1 : LOAD_LAT;

  entry_t entry_q [DEPTH];
  entry_t entry_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             hit_a, hit_b;
  logic             load_a, load_b;
  logic [SEL_W-1:0] k_a, k_b;

  hazard_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_a (
    .entries_i (entry_q),
    .src_i     (rs_d),
    .use_i     (use_rs),
    .hit_o     (hit_a),
    .k_o       (k_a),
    .is_load_o (load_a)
  );

  hazard_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_b (
    .entries_i (entry_q),
    .src_i     (rt_d),
    .use_i     (use_rt),
    .hit_o     (hit_b),
    .k_o       (k_b),
    .is_load_o (load_b)
  );

  logic ld_use_a, ld_use_b, br_a, br_b;

  // Load data is not yet available before stage LD_LAT; a branch needs its
  // operands one stage earlier, so any execute-stage producer also stalls it.
  always_comb begin
    ld_use_a = hit_a & load_a & (32'(k_a) < LD_LAT);
    ld_use_b = hit_b & load_b & (32'(k_b) < LD_LAT);
    br_a     = is_branch_d & hit_a & ((k_a == '0) | (load_a & (32'(k_a) < LD_LAT + 1)));
    br_b     = is_branch_d & hit_b & ((k_b == '0) | (load_b & (32'(k_b) < LD_LAT + 1)));
    stall_d  = issue_valid & (ld_use_a | ld_use_b | br_a | br_b);
    fwd_a    = hit_a ? k_a + SEL_W'(1) : SEL_W'(FWD_RF);
    fwd_b    = hit_b ? k_b + SEL_W'(1) : SEL_W'(FWD_RF);
    stall_cnt = cnt_q;
  end

  // Shift pipeline and stall counter next state; hold freezes everything.
  always_comb begin
    for (int k = 0; k < int'(DEPTH); k++) entry_d[k] = entry_q[k];
    cnt_d = cnt_q;
    if (!hold) begin
      for (int k = 1; k < int'(DEPTH); k++) entry_d[k] = entry_q[k-1];
      if (stall_d || flush_e || !issue_valid) begin
        entry_d[0] = '0;
      end else begin
        entry_d[0] = '{valid: 1'b1, dest: MAX_REG_AW'(dest_d), we: we_d, load: load_d};
      end
      if (stall_d && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < int'(DEPTH); k++) entry_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) entry_q[k] <= entry_d[k];
      cnt_q <= cnt_d;
    end
  end

endmodule
